// File: rtl/tl_pkg.sv
// tl_pkg: shared state encoding, default phase durations and round-robin pick
package tl_pkg;
  typedef enum logic [2:0] {IDLE, ALL_RED, RED_YELLOW, GREEN, YELLOW, FLASH} tl_state_e;
  localparam int T_RY_DEF = 2;
  localparam int T_GREEN_DEF = 4;
  localparam int T_YELLOW_DEF = 3;
  localparam int T_ALLRED_DEF = 1;
  function automatic int rr_next(input int cur, input logic [31:0] req, input int n);
    int r;
    r = (cur + 1) % n;
    for (int i = 32; i >= 1; i--)
      if (i <= n && req[(cur + i) % n]) r = (cur + i) % n;
    return r;
  endfunction
endpackage

// File: rtl/tl_dwell_timer.sv
// tl_dwell_timer: loadable down-counter that parks at zero, advancing only on en
module tl_dwell_timer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          expired
);
  logic [DW-1:0] cnt;
  // load on phase entry, otherwise count down to zero and hold there
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= load ? load_val : cnt != '0 ? cnt - 1'b1 : cnt;
  assign expired = cnt == '0;
endmodule

// File: rtl/tl_multi_ctrl.sv
// tl_multi_ctrl: round-robin multi-approach traffic-light controller with flash mode
module tl_multi_ctrl
  import tl_pkg::*;
#(
  parameter int N_DIR = 2,
  parameter int DW = 8,
  parameter int T_RY = T_RY_DEF,
  parameter int T_GREEN = T_GREEN_DEF,
  parameter int T_YELLOW = T_YELLOW_DEF,
  parameter int T_ALLRED = T_ALLRED_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     en,
  input  logic                     flash,
  input  logic [N_DIR-1:0]         dir_req,
  output logic [N_DIR-1:0]         red,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         green,
  output logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic                     busy
);
  localparam int CW = $clog2(N_DIR);
  tl_state_e st, nxt;
  logic ld, expired, blink, other;
  logic [DW-1:0] ld_val;
  logic [N_DIR-1:0] oh;
  assign oh = N_DIR'(1) << cur_dir;
  assign other = |(dir_req & ~oh);
  tl_dwell_timer #(.DW(DW)) u_timer (
    .clk(clk), .rst(rst), .en(en), .load(ld), .load_val(ld_val), .expired(expired)
  );
  // next phase: flash overrides everything but IDLE; green lingers until someone else asks
  always_comb begin
    nxt = st;
    ld = 1'b0;
    ld_val = '0;
    if (st == IDLE) begin
      if (start) begin
        nxt = ALL_RED;
        ld = 1'b1;
        ld_val = DW'(T_ALLRED - 1);
      end
    end else if (st != FLASH && flash) nxt = FLASH;
    else if (st == FLASH ? !flash : expired && (st != GREEN || other)) begin
      nxt = st == ALL_RED ? RED_YELLOW : st == RED_YELLOW ? GREEN : st == GREEN ? YELLOW : ALL_RED;
      ld = 1'b1;
      ld_val = nxt == RED_YELLOW ? DW'(T_RY - 1) : nxt == GREEN ? DW'(T_GREEN - 1) :
               nxt == YELLOW ? DW'(T_YELLOW - 1) : DW'(T_ALLRED - 1);
    end
  end
  // state, served approach and flash phase register; approach changes only leaving ALL_RED
  always_ff @(posedge clk)
    if (rst) begin
      st <= IDLE;
      cur_dir <= CW'(N_DIR - 1);
      blink <= 1'b0;
    end else if (en) begin
      st <= nxt;
      blink <= st == FLASH && nxt == FLASH ? ~blink : 1'b0;
      if (st == ALL_RED && nxt == RED_YELLOW) cur_dir <= CW'(rr_next(int'(cur_dir), 32'(dir_req), N_DIR));
    end
  // lamp decode from registered state only
  always_comb begin
    red = st == ALL_RED || st == RED_YELLOW ? {N_DIR{1'b1}} : st == GREEN || st == YELLOW ? ~oh : '0;
    yellow = st == RED_YELLOW || st == YELLOW ? oh : st == FLASH ? {N_DIR{blink}} : '0;
    green = st == GREEN ? oh : '0;
    busy = st != IDLE;
  end
endmodule

// File: tb/tb_tl_multi_ctrl.sv
// tb_tl_multi_ctrl: scoreboarded directed test of a 2-way and a 4-way controller
module tb_tl_multi_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, en = 1'b1, flash = 1'b0;
  logic [1:0] req2 = '0;
  logic [1:0] red2, yel2, grn2;
  logic cd2, busy2;
  logic rst4 = 1'b1, start4 = 1'b0, flash4 = 1'b0;
  logic [3:0] req4 = '0;
  logic [3:0] red4, yel4, grn4;
  logic [1:0] cd4;
  logic busy4;
  int cnt = 0, total = 0, pass = 0;
  typedef struct {int cyc; bit d4; string nm; logic [14:0] e;} item_t;
  item_t q[$];
  item_t mit;
  logic [14:0] act;

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  tl_multi_ctrl #(.N_DIR(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .en(en), .flash(flash), .dir_req(req2),
    .red(red2), .yellow(yel2), .green(grn2), .cur_dir(cd2), .busy(busy2)
  );
  tl_multi_ctrl #(.N_DIR(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .en(en), .flash(flash4), .dir_req(req4),
    .red(red4), .yellow(yel4), .green(grn4), .cur_dir(cd4), .busy(busy4)
  );

  // monitor: compare every expectation due by this cycle against the presented lamps
  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cnt) begin
      mit = q.pop_front();
      act = mit.d4 ? {red4, yel4, grn4, cd4, busy4}
                   : {2'b0, red2, 2'b0, yel2, 2'b0, grn2, 1'b0, cd2, busy2};
      total++;
      if (act === mit.e) pass++;
      else $display("FAIL %s cyc=%0d got r/y/g/cd/busy=%h_%h_%h_%0d_%b expected %h_%h_%h_%0d_%b",
                    mit.nm, mit.cyc, act[14:11], act[10:7], act[6:3], act[2:1], act[0],
                    mit.e[14:11], mit.e[10:7], mit.e[6:3], mit.e[2:1], mit.e[0]);
    end

  // drive one set of inputs for n edges, expecting the given outputs after each edge
  task automatic v(input bit d4, input string nm, input int n, input logic st, input logic en_i,
                   input logic fl, input logic [3:0] rq, input logic rs, input logic [3:0] r,
                   input logic [3:0] y, input logic [3:0] g, input logic [1:0] cd, input logic b);
    for (int k = 0; k < n; k++) begin
      en = en_i;
      if (d4) begin
        rst4 = rs; start4 = st; req4 = rq;
      end else begin
        rst = rs; start = st; flash = fl; req2 = rq[1:0];
      end
      q.push_back('{cnt + 1, d4, nm, {r, y, g, cd, b}});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    v(0, "reset", 2, 1, 1, 0, 2, 1, 0, 0, 0, 1, 0);
    v(0, "allred", 1, 1, 1, 0, 2, 0, 3, 0, 0, 1, 1);
    v(0, "ry_d1", 2, 0, 1, 0, 2, 0, 3, 2, 0, 1, 1);
    v(0, "green_d1", 4, 0, 1, 0, 2, 0, 1, 0, 2, 1, 1);
    v(0, "green_d1_hold", 3, 0, 1, 0, 2, 0, 1, 0, 2, 1, 1);
    v(0, "yellow_d1", 3, 0, 1, 0, 1, 0, 1, 2, 0, 1, 1);
    v(0, "allred2", 1, 0, 1, 0, 1, 0, 3, 0, 0, 1, 1);
    v(0, "ry_d0", 1, 0, 1, 0, 1, 0, 3, 1, 0, 0, 1);
    v(0, "ry_en0", 1, 0, 0, 0, 1, 0, 3, 1, 0, 0, 1);
    v(0, "ry_en1", 1, 0, 1, 0, 1, 0, 3, 1, 0, 0, 1);
    v(0, "ry_en0b", 1, 0, 0, 0, 1, 0, 3, 1, 0, 0, 1);
    v(0, "green_d0_gated", 1, 0, 1, 0, 1, 0, 2, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      v(0, "green_en0", 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 1);
      v(0, "green_en1", 1, 0, 1, 0, 0, 0, 2, 0, 1, 0, 1);
    end
    v(0, "green_noreq_hold", 5, 0, 1, 0, 0, 0, 2, 0, 1, 0, 1);
    v(0, "yellow_d0_fast", 1, 0, 1, 0, 2, 0, 2, 1, 0, 0, 1);
    v(0, "yellow_d0", 2, 0, 1, 0, 0, 0, 2, 1, 0, 0, 1);
    v(0, "allred3", 1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 1);
    v(0, "ry_noreq_d1", 2, 0, 1, 0, 0, 0, 3, 2, 0, 1, 1);
    v(0, "green_d1_noreq", 6, 0, 1, 0, 0, 0, 1, 0, 2, 1, 1);
    v(0, "yellow_d1b", 1, 0, 1, 0, 1, 0, 1, 2, 0, 1, 1);
    v(0, "yellow_d1c", 2, 0, 1, 0, 0, 0, 1, 2, 0, 1, 1);
    v(0, "allred4", 1, 0, 1, 0, 0, 0, 3, 0, 0, 1, 1);
    v(0, "ry_wrap_d0", 2, 0, 1, 0, 0, 0, 3, 1, 0, 0, 1);
    v(0, "green_d0b", 2, 0, 1, 0, 0, 0, 2, 0, 1, 0, 1);
    v(0, "flash_entry", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, "flash_on", 1, 0, 1, 1, 0, 0, 0, 3, 0, 0, 1);
    v(0, "flash_off", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, "flash_on2", 1, 0, 1, 1, 0, 0, 0, 3, 0, 0, 1);
    v(0, "flash_en0", 1, 0, 0, 1, 0, 0, 0, 3, 0, 0, 1);
    v(0, "flash_off2", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    v(0, "flash_exit_ar", 1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 1);
    v(0, "ry_after_flash", 2, 0, 1, 0, 0, 0, 3, 2, 0, 1, 1);
    v(0, "green_d1c", 4, 0, 1, 0, 1, 0, 1, 0, 2, 1, 1);
    v(0, "yellow_d1d", 1, 0, 1, 0, 1, 0, 1, 2, 0, 1, 1);
    v(0, "rst_in_yellow", 1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    v(0, "rst_hold_start", 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0);
    v(0, "idle_flash_ignored", 2, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    v(1, "rst4", 1, 0, 1, 0, 9, 1, 0, 0, 0, 3, 0);
    v(1, "allred4w", 1, 1, 1, 0, 9, 0, 15, 0, 0, 3, 1);
    v(1, "ry4_d0", 2, 0, 1, 0, 9, 0, 15, 1, 0, 0, 1);
    v(1, "green4_d0", 4, 0, 1, 0, 9, 0, 14, 0, 1, 0, 1);
    v(1, "yellow4_d0", 3, 0, 1, 0, 9, 0, 14, 1, 0, 0, 1);
    v(1, "allred4b", 1, 0, 1, 0, 9, 0, 15, 0, 0, 0, 1);
    v(1, "ry4_d3", 2, 0, 1, 0, 9, 0, 15, 8, 0, 3, 1);
    v(1, "green4_d3", 4, 0, 1, 0, 9, 0, 7, 0, 8, 3, 1);
    v(1, "yellow4_d3", 3, 0, 1, 0, 9, 0, 7, 8, 0, 3, 1);
    v(1, "allred4c", 1, 0, 1, 0, 9, 0, 15, 0, 0, 3, 1);
    v(1, "ry4_d0_again", 1, 0, 1, 0, 9, 0, 15, 1, 0, 0, 1);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain left=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
